// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter: access modes, FSM states and access size.
package dmem_pkg;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Illegal modes report 4 bytes; they are rejected by the mode check anyway.
  function automatic logic [2:0] size_of(input logic [2:0] mode);
    case (mode)
      MODE_B, MODE_BU: size_of = 3'd1;
      MODE_H, MODE_HU: size_of = 3'd2;
      default:         size_of = 3'd4;
    endcase
  endfunction

  function automatic logic mode_bad(input logic [2:0] mode);
    mode_bad = (mode == 3'b011) || (mode == 3'b110) || (mode == 3'b111);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on ties, or fixed priority to port 0.
// Combinational winner; the last-grant pointer only moves when the caller takes the winner.
module rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic       o_any,
  output logic       o_win
);

  logic r_last;

  always_comb begin
    o_any = |i_req;
    if (i_req == 2'b11) begin
      o_win = FIXED_PRIO ? 1'b0 : ~r_last;
    end else begin
      o_win = i_req[1];
    end
  end

  // Reset to "port 1 granted last" so the first tie goes to port 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (i_take && o_any) begin
      r_last <= o_win;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data memory between two request ports; req in cycle N -> gnt N+1 -> rvalid N+2.
// Requests are held until gnt; checks reject bad accesses before they reach memory.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_SIZE   = 1024,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [31:0]           p0_wdata,
  input  logic [2:0]            p0_mode,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic                  p0_err,
  output logic [31:0]           p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [31:0]           p1_wdata,
  input  logic [2:0]            p1_mode,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic                  p1_err,
  output logic [31:0]           p1_rdata,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [2:0]            mem_mode,
  input  logic [31:0]           mem_rdata
);

  localparam logic [ADDR_WIDTH:0] LP_MEM_END = (ADDR_WIDTH+1)'(MEM_SIZE);

  state_t                r_state;
  logic                  r_id;
  logic                  r_we;
  logic                  r_bad;
  logic                  r_mem_write;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic [2:0]            r_mem_mode;
  logic [1:0]            r_gnt;
  logic [1:0]            r_rvalid;
  logic [1:0]            r_err;
  logic [1:0][31:0]      r_rdata;

  logic                  w_take;
  logic                  w_any;
  logic                  w_win;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [31:0]           w_wdata;
  logic [2:0]            w_mode;
  logic [ADDR_WIDTH:0]   w_end;
  logic                  w_misaligned;
  logic                  w_bad;

  // The port in ACCESS is never re-arbitrated; its held req is ignored there.
  assign w_take = (r_state != ST_ACCESS);

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  ({p1_req, p0_req}),
    .i_take (w_take),
    .o_any  (w_any),
    .o_win  (w_win)
  );

  always_comb begin
    w_we    = w_win ? p1_we    : p0_we;
    w_addr  = w_win ? p1_addr  : p0_addr;
    w_wdata = w_win ? p1_wdata : p0_wdata;
    w_mode  = w_win ? p1_mode  : p0_mode;

    case (w_mode)
      MODE_H, MODE_HU: w_misaligned = w_addr[0];
      MODE_W:          w_misaligned = |w_addr[1:0];
      default:         w_misaligned = 1'b0;
    endcase

    w_end = {1'b0, w_addr} + {{(ADDR_WIDTH-2){1'b0}}, size_of(w_mode)};
    w_bad = mode_bad(w_mode) || w_misaligned || (w_end > LP_MEM_END);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_id        <= 1'b0;
      r_we        <= 1'b0;
      r_bad       <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_mode  <= '0;
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_err       <= '0;
      r_rdata     <= '0;
    end else begin
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_err       <= '0;
      r_mem_write <= 1'b0;
      case (r_state)
        ST_ACCESS: begin
          r_rvalid[r_id] <= 1'b1;
          r_err[r_id]    <= r_bad;
          r_rdata[r_id]  <= (r_we || r_bad) ? 32'h0 : mem_rdata;
          r_state        <= ST_RESP;
        end
        default: begin
          if (w_any) begin
            r_id        <= w_win;
            r_we        <= w_we;
            r_bad       <= w_bad;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
            r_mem_mode  <= w_mode;
            r_mem_write <= w_we && !w_bad;
            r_gnt[w_win] <= 1'b1;
            r_state     <= ST_ACCESS;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Reset gates the write strobe combinationally so a reset cycle never writes.
  assign mem_write = r_mem_write & rst_n;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_mode  = r_mem_mode;

  assign p0_gnt    = r_gnt[0];
  assign p1_gnt    = r_gnt[1];
  assign p0_rvalid = r_rvalid[0];
  assign p1_rvalid = r_rvalid[1];
  assign p0_err    = r_err[0];
  assign p1_err    = r_err[1];
  assign p0_rdata  = r_rdata[0];
  assign p1_rdata  = r_rdata[1];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a little-endian byte memory that sign/zero-extends loads.
module tb_dmem_port_arbiter;

  localparam logic [2:0] MB = 3'b000, MH = 3'b001, MW = 3'b010, MBU = 3'b100, MHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [11:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic [2:0]  p0_mode, p1_mode;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_write;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [2:0]  mem_mode;

  logic        fp_p0_gnt, fp_p0_rvalid, fp_p0_err, fp_p1_gnt, fp_p1_rvalid, fp_p1_err;
  logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_mem_wdata;
  logic        fp_mem_write;
  logic [11:0] fp_mem_addr;
  logic [2:0]  fp_mem_mode;
  logic [31:0] fp_mem_rdata;

  int ncmp = 0;
  int nfail = 0;
  int wr_cnt = 0;

  always #5 clk = ~clk;
  assign fp_mem_rdata = 32'h0;

  dmem_port_arbiter #(.ADDR_WIDTH(12), .MEM_SIZE(1024), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_mode(p0_mode),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_mode(p1_mode),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mode(mem_mode),
    .mem_rdata(mem_rdata)
  );

  dmem_port_arbiter #(.ADDR_WIDTH(12), .MEM_SIZE(1024), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_mode(p0_mode),
    .p0_gnt(fp_p0_gnt), .p0_rvalid(fp_p0_rvalid), .p0_err(fp_p0_err), .p0_rdata(fp_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_mode(p1_mode),
    .p1_gnt(fp_p1_gnt), .p1_rvalid(fp_p1_rvalid), .p1_err(fp_p1_err), .p1_rdata(fp_p1_rdata),
    .mem_write(fp_mem_write), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_mode(fp_mem_mode),
    .mem_rdata(fp_mem_rdata)
  );

  // Byte memory behind the main instance.
  logic [7:0]  mem [0:4095];
  logic [11:0] ma1, ma2, ma3;

  always_comb begin
    ma1 = mem_addr + 12'd1;
    ma2 = mem_addr + 12'd2;
    ma3 = mem_addr + 12'd3;
    case (mem_mode)
      MB:      mem_rdata = {{24{mem[mem_addr][7]}}, mem[mem_addr]};
      MBU:     mem_rdata = {24'h0, mem[mem_addr]};
      MH:      mem_rdata = {{16{mem[ma1][7]}}, mem[ma1], mem[mem_addr]};
      MHU:     mem_rdata = {16'h0, mem[ma1], mem[mem_addr]};
      default: mem_rdata = {mem[ma3], mem[ma2], mem[ma1], mem[mem_addr]};
    endcase
  end

  always @(posedge clk) begin
    if (!rst_n && $time < 20) begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    end else if (mem_write) begin
      wr_cnt = wr_cnt + 1;
      mem[mem_addr] = mem_wdata[7:0];
      if (mem_mode[1:0] != 2'b00) mem[ma1] = mem_wdata[15:8];
      if (mem_mode[1:0] == 2'b10) begin
        mem[ma2] = mem_wdata[23:16];
        mem[ma3] = mem_wdata[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit port, input bit req, input bit we, input logic [11:0] addr,
                       input logic [31:0] wd, input logic [2:0] mode);
    if (port) begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd; p1_mode = mode;
    end else begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd; p0_mode = mode;
    end
  endtask

  // One access on one port: returns the cycle offsets of gnt and rvalid (-1 if never seen).
  task automatic access(input bit port, input bit we, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [2:0] mode, output logic [31:0] rd, output logic er,
                        output int gc, output int rc);
    drive(port, 1'b1, we, addr, wd, mode);
    gc = -1; rc = -1; rd = 'x; er = 1'bx;
    for (int c = 1; c <= 12; c++) begin
      step();
      if ((port ? p1_gnt : p0_gnt) && gc < 0) begin
        gc = c;
        drive(port, 1'b0, we, addr, wd, mode);
      end
      if (port ? p1_rvalid : p0_rvalid) begin
        rc = c;
        rd = port ? p1_rdata : p0_rdata;
        er = port ? p1_err : p0_err;
        break;
      end
    end
    drive(port, 1'b0, we, addr, wd, mode);
  endtask

  task automatic op(input string tag, input bit port, input bit we, input logic [11:0] addr,
                    input logic [31:0] wd, input logic [2:0] mode,
                    input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    int          gc, rc;
    access(port, we, addr, wd, mode, rd, er, gc, rc);
    chk({tag, ".gnt_cyc"}, gc, 32'd1);
    chk({tag, ".rvalid_cyc"}, rc, 32'd2);
    chk({tag, ".rdata"}, rd, exp_rd);
    chk({tag, ".err"}, {31'h0, er}, {31'h0, exp_er});
  endtask

  initial begin
    int w0;
    int n0, nf;
    logic g0 [0:7];
    logic gf [0:7];

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, MW);
    drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, MW);
    step(); step();
    rst_n = 1'b1;
    step();

    chk("rst.gnt",    {28'h0, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}, 32'h0);
    chk("rst.err",    {30'h0, p0_err, p1_err}, 32'h0);
    chk("rst.rdata0", p0_rdata, 32'h0);
    chk("rst.rdata1", p1_rdata, 32'h0);
    chk("rst.mem",    {19'h0, mem_write, mem_addr}, 32'h0);
    chk("rst.mem_wd", mem_wdata, 32'h0);
    chk("rst.mem_md", {29'h0, mem_mode}, 32'h0);

    // Basic store then load
    op("sw010", 1'b0, 1'b1, 12'h010, 32'hDEADBEEF, MW, 32'h0, 1'b0);
    op("lw010", 1'b0, 1'b0, 12'h010, 32'h0, MW, 32'hDEADBEEF, 1'b0);

    // Sign/zero extension
    op("sb020",  1'b0, 1'b1, 12'h020, 32'h00000080, MB, 32'h0, 1'b0);
    op("lb020",  1'b0, 1'b0, 12'h020, 32'h0, MB,  32'hFFFFFF80, 1'b0);
    op("lbu020", 1'b1, 1'b0, 12'h020, 32'h0, MBU, 32'h00000080, 1'b0);
    op("sh020",  1'b1, 1'b1, 12'h020, 32'h00008001, MH, 32'h0, 1'b0);
    op("lh020",  1'b0, 1'b0, 12'h020, 32'h0, MH,  32'hFFFF8001, 1'b0);
    op("lhu020", 1'b0, 1'b0, 12'h020, 32'h0, MHU, 32'h00008001, 1'b0);

    // Rejected accesses never write
    w0 = wr_cnt;
    op("sw013_mis",  1'b0, 1'b1, 12'h013, 32'h11111111, MW, 32'h0, 1'b1);
    op("sh3ff_oor",  1'b1, 1'b1, 12'h3FF, 32'h00002222, MH, 32'h0, 1'b1);
    op("st_mode011", 1'b0, 1'b1, 12'h010, 32'h33333333, 3'b011, 32'h0, 1'b1);
    op("lw011_mis",  1'b1, 1'b0, 12'h011, 32'h0, MW, 32'h0, 1'b1);
    op("lb400_oor",  1'b0, 1'b0, 12'h400, 32'h0, MB, 32'h0, 1'b1);
    chk("err.no_write", wr_cnt, w0);
    op("lw010_keep", 1'b0, 1'b0, 12'h010, 32'h0, MW, 32'hDEADBEEF, 1'b0);
    op("lw3fc_edge", 1'b1, 1'b0, 12'h3FC, 32'h0, MW, 32'h0, 1'b0);

    // Reset during an ACCESS cycle abandons the store
    op("sw040", 1'b0, 1'b1, 12'h040, 32'hCAFEF00D, MW, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 12'h040, 32'h12345678, MW);
    step();
    chk("rstacc.gnt1", {31'h0, p1_gnt}, 32'h1);
    drive(1'b1, 1'b0, 1'b1, 12'h040, 32'h12345678, MW);
    w0 = wr_cnt;
    rst_n = 1'b0;
    #1;
    chk("rstacc.mem_write", {31'h0, mem_write}, 32'h0);
    step();
    chk("rstacc.rvalid1", {31'h0, p1_rvalid}, 32'h0);
    step();
    rst_n = 1'b1;
    chk("rstacc.no_write", wr_cnt, w0);
    chk("rstacc.rdata1", p1_rdata, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 12'h040, 32'h0, MW);
    drive(1'b1, 1'b1, 1'b0, 12'h040, 32'h0, MW);
    step();
    chk("rstacc.tie_gnt", {30'h0, p1_gnt, p0_gnt}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 12'h040, 32'h0, MW);
    step();
    chk("rstacc.rv0", {31'h0, p0_rvalid}, 32'h1);
    chk("rstacc.rd0", p0_rdata, 32'hCAFEF00D);
    step();
    chk("rstacc.gnt1b", {30'h0, p1_gnt, p0_gnt}, 32'h2);
    drive(1'b1, 1'b0, 1'b0, 12'h040, 32'h0, MW);
    step();
    chk("rstacc.rv1", {31'h0, p1_rvalid}, 32'h1);
    chk("rstacc.rd1", p1_rdata, 32'hCAFEF00D);

    // Both ports requesting continuously: round-robin vs fixed priority
    n0 = 0; nf = 0;
    drive(1'b0, 1'b1, 1'b0, 12'h010, 32'h0, MW);
    drive(1'b1, 1'b1, 1'b0, 12'h020, 32'h0, MW);
    for (int c = 0; c < 40 && n0 < 6; c++) begin
      step();
      if (p0_gnt && p1_gnt) chk("rr.both_gnt", 32'h1, 32'h0);
      if ((p0_gnt || p1_gnt) && n0 < 8) begin g0[n0] = p1_gnt; n0++; end
      if ((fp_p0_gnt || fp_p1_gnt) && nf < 8) begin gf[nf] = fp_p1_gnt; nf++; end
    end
    drive(1'b0, 1'b0, 1'b0, 12'h010, 32'h0, MW);
    drive(1'b1, 1'b0, 1'b0, 12'h020, 32'h0, MW);
    chk("rr.count", n0, 32'd6);
    chk("fp.count", nf, 32'd6);
    if (n0 == 6 && nf == 6) begin
      chk("rr.seq", {26'h0, g0[5], g0[4], g0[3], g0[2], g0[1], g0[0]}, 32'b101010);
      chk("fp.seq", {26'h0, gf[5], gf[4], gf[3], gf[2], gf[1], gf[0]}, 32'b000000);
    end
    step(); step(); step();
    chk("rr.idle", {28'h0, p0_gnt, p1_gnt, mem_write, fp_mem_write}, 32'h0);

    // p1 arrives while p0 is in ACCESS
    drive(1'b0, 1'b1, 1'b0, 12'h010, 32'h0, MW);
    step();
    chk("ovl.gnt0", {30'h0, p1_gnt, p0_gnt}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 12'h010, 32'h0, MW);
    drive(1'b1, 1'b1, 1'b0, 12'h040, 32'h0, MW);
    step();
    chk("ovl.rv0", {30'h0, p1_gnt, p0_rvalid}, 32'h1);
    chk("ovl.rd0", p0_rdata, 32'hDEADBEEF);
    step();
    chk("ovl.gnt1", {30'h0, p1_gnt, p0_rvalid}, 32'h2);
    drive(1'b1, 1'b0, 1'b0, 12'h040, 32'h0, MW);
    step();
    chk("ovl.rv1", {30'h0, p1_rvalid, p1_err}, 32'h2);
    chk("ovl.rd1", p1_rdata, 32'hCAFEF00D);
    chk("ovl.rd0_held", p0_rdata, 32'hDEADBEEF);
    chk("fp.rd0_held", {31'h0, fp_p0_err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
